// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution / pooling / requant datapath blocks.
package conv_pkg;

   localparam int unsigned DEF_DW    = 8;
   localparam int unsigned DEF_WW    = 8;
   localparam int unsigned DEF_OUT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_e;

   // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Clamp a signed value into the range of a signed width-bit number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = ~hi;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/conv_shift_sat.sv
// Arithmetic right shift (floor), optional ReLU and signed saturation of an
// accumulator down to the output width.
module conv_shift_sat
   import conv_pkg::*;
#(
   parameter int unsigned ACC_W = 21,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned SH_W  = 5
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [SH_W-1:0]  shift,
   input  logic             relu,
   output logic [OUT_W-1:0] res_c
);

   logic signed [ACC_W-1:0] shifted;
   logic signed [63:0]      wide;

   always_comb begin
      shifted = $signed(acc) >>> shift;
      wide    = 64'(shifted);
      if (relu && wide[63]) begin
         wide = '0;
      end
      res_c = OUT_W'(sat_signed(wide, OUT_W));
   end

endmodule

// File: rtl/conv_kxk_mac.sv
// KxK signed convolution MAC: one output pixel per transaction, LANES taps per
// cycle, bias preload, shift/ReLU/saturate on the way out.
module conv_kxk_mac
   import conv_pkg::*;
#(
   parameter int unsigned KSIZE = 3,
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned WW    = DEF_WW,
   parameter int unsigned LANES = 1,
   parameter int unsigned BW    = 16,
   parameter int unsigned ACC_W = DW + WW + clog2(KSIZE * KSIZE) + 1,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned SH_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [KSIZE*KSIZE*DW-1:0]   in_data,
   input  logic [KSIZE*KSIZE*WW-1:0]   in_weight,
   input  logic [BW-1:0]               in_bias,
   input  logic [SH_W-1:0]             in_shift,
   input  logic                        in_relu,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_data
);

   localparam int unsigned NTAP   = KSIZE * KSIZE;
   localparam int unsigned STEPS  = (NTAP + LANES - 1) / LANES;
   localparam int unsigned NPAD   = STEPS * LANES;
   localparam int unsigned STEP_W = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;
   localparam int unsigned PW     = DW + WW;

   state_e                  state_q, state_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [STEP_W-1:0]       step_q, step_d;
   logic [NPAD*DW-1:0]      data_q, data_d;
   logic [NPAD*WW-1:0]      weight_q, weight_d;
   logic [SH_W-1:0]         shift_q, shift_d;
   logic                    relu_q, relu_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_W-1:0]        out_data_q, out_data_d;

   logic [ACC_W-1:0]        lane_ext [LANES];
   logic [ACC_W-1:0]        lane_sum;
   logic [ACC_W-1:0]        acc_sum;
   logic [OUT_W-1:0]        res_c;

   // Lanes always read the low LANES taps; the tap registers shift down each step,
   // and the zero padding above NTAP makes the ragged final step contribute nothing.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DW-1:0] a;
      logic signed [WW-1:0] b;
      logic signed [PW-1:0] p;
      assign a           = data_q[l*DW +: DW];
      assign b           = weight_q[l*WW +: WW];
      assign p           = PW'(a) * PW'(b);
      assign lane_ext[l] = ACC_W'(p);
   end

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + lane_ext[l];
      end
      acc_sum = acc_q + lane_sum;
   end

   conv_shift_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
   ) u_shift_sat (
      .acc   (acc_sum),
      .shift (shift_q),
      .relu  (relu_q),
      .res_c (res_c)
   );

   // Next-state and handshake logic; capture is shared by IDLE and the OUT fast path.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      step_d      = step_q;
      data_d      = data_q;
      weight_d    = weight_q;
      shift_d     = shift_q;
      relu_d      = relu_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      in_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         ACCUM: begin
            acc_d    = acc_sum;
            step_d   = step_q + STEP_W'(1);
            data_d   = data_q >> (LANES * DW);
            weight_d = weight_q >> (LANES * WW);
            if (step_q == STEP_W'(STEPS - 1)) begin
               out_data_d  = res_c;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            in_ready = out_ready;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (in_valid && in_ready) begin
         data_d                  = '0;
         data_d[NTAP*DW-1:0]     = in_data;
         weight_d                = '0;
         weight_d[NTAP*WW-1:0]   = in_weight;
         shift_d                 = in_shift;
         relu_d                  = in_relu;
         acc_d                   = ACC_W'($signed(in_bias));
         step_d                  = '0;
         state_d                 = ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         step_q      <= '0;
         data_q      <= '0;
         weight_q    <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         data_q      <= data_d;
         weight_q    <= weight_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   a_shift_legal: assert property (@(posedge clk) disable iff (rst)
      (in_valid && in_ready) |-> (32'(in_shift) < ACC_W));

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Directed bench for conv_kxk_mac: a LANES=1 and a LANES=4 instance share the
// window/config inputs and are exercised one at a time.
module tb_conv_kxk_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid1, in_valid4;
   logic        in_ready1, in_ready4;
   logic [71:0] in_data;
   logic [71:0] in_weight;
   logic [15:0] in_bias;
   logic [4:0]  in_shift;
   logic        in_relu;
   logic        out_ready;
   logic        out_valid1, out_valid4;
   logic [7:0]  out_data1, out_data4;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   conv_kxk_mac #(.LANES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
      .in_shift(in_shift), .in_relu(in_relu), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1)
   );

   conv_kxk_mac #(.LANES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
      .in_shift(in_shift), .in_relu(in_relu), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4)
   );

   task automatic set_uniform(input int d, input int w, input int b, input int sh, input bit r);
      for (int i = 0; i < 9; i++) begin
         in_data[i*8 +: 8]   = 8'(d);
         in_weight[i*8 +: 8] = 8'(w);
      end
      in_bias  = 16'(b);
      in_shift = 5'(sh);
      in_relu  = r;
   endtask

   task automatic set_ramp(input int w, input int b);
      for (int i = 0; i < 9; i++) begin
         in_data[i*8 +: 8]   = 8'(i + 1);
         in_weight[i*8 +: 8] = 8'(w);
      end
      in_bias  = 16'(b);
      in_shift = 5'd0;
      in_relu  = 1'b0;
   endtask

   // One transaction from IDLE; lat counts the handshake cycle as cycle 0.
   task automatic run_txn(input bit use4, output int lat, output int res);
      lat = 0;
      res = 0;
      if (use4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      in_valid4 = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         if (use4 ? out_valid4 : out_valid1) begin
            lat = k;
            res = use4 ? int'($signed(out_data4)) : int'($signed(out_data1));
            break;
         end
         @(posedge clk); #1;
      end
      if (lat == 0) begin
         total++;
         $display("FAIL txn_timeout: no out_valid within 50 cycles (lanes4=%0d)", use4);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready1, out_valid1, out_data1} !== 10'b1_0_00000000)
         $display("FAIL reset_l1: ready=%0b valid=%0b data=%0d, want 1 0 0", in_ready1, out_valid1, out_data1);
      else pass_cnt++;
      total++;
      if ({in_ready4, out_valid4, out_data4} !== 10'b1_0_00000000)
         $display("FAIL reset_l4: ready=%0b valid=%0b data=%0d, want 1 0 0", in_ready4, out_valid4, out_data4);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ones();
      int lat, res;
      set_uniform(1, 1, 0, 0, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 9) $display("FAIL ones_data: got %0d want 9", res); else pass_cnt++;
      total++;
      if (lat !== 10) $display("FAIL ones_latency: got %0d want 10", lat); else pass_cnt++;
   endtask

   task automatic test_saturate();
      int lat, res;
      set_uniform(127, 127, 0, 8, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 127) $display("FAIL sat_pos: got %0d want 127", res); else pass_cnt++;
      set_uniform(-128, 127, 0, 8, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== -128) $display("FAIL sat_neg: got %0d want -128", res); else pass_cnt++;
      set_uniform(-128, 127, 0, 8, 1'b1);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 0) $display("FAIL relu_neg: got %0d want 0", res); else pass_cnt++;
   endtask

   task automatic test_lanes();
      int lat, res;
      set_ramp(-1, 100);
      run_txn(1'b1, lat, res);
      total++;
      if (res !== 55) $display("FAIL lanes4_data: got %0d want 55", res); else pass_cnt++;
      total++;
      if (lat !== 4) $display("FAIL lanes4_latency: got %0d want 4", lat); else pass_cnt++;
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 55) $display("FAIL lanes1_ramp: got %0d want 55", res); else pass_cnt++;
   endtask

   task automatic test_shift_floor();
      int lat, res;
      set_uniform(0, 0, -32768, 4, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== -128) $display("FAIL bias_min_sat: got %0d want -128", res); else pass_cnt++;
      set_uniform(0, 0, -1, 1, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== -1) $display("FAIL floor_neg: got %0d want -1", res); else pass_cnt++;
      set_uniform(0, 0, 3, 1, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 1) $display("FAIL floor_pos: got %0d want 1", res); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int lat, res;
      bit seen;
      set_uniform(2, 3, 0, 0, 1'b0);
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({in_ready1, out_valid1, out_data1} !== 10'b1_0_00000000)
         $display("FAIL mid_reset: ready=%0b valid=%0b data=%0d, want 1 0 0", in_ready1, out_valid1, out_data1);
      else pass_cnt++;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid1) seen = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL mid_reset_no_pulse: out_valid seen=%0b want 0", seen); else pass_cnt++;
      set_uniform(1, 1, 5, 0, 1'b0);
      run_txn(1'b0, lat, res);
      total++;
      if (res !== 14) $display("FAIL after_reset_data: got %0d want 14", res); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int t1, t2, r1, r2, n;
      t1 = 0; t2 = 0; r1 = 0; r2 = 0; n = 0;
      out_ready = 1'b1;
      set_ramp(1, 0);
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      set_uniform(3, 2, -10, 0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (n == 1 && k == t1 + 1) in_valid4 = 1'b0;
         if (out_valid4) begin
            if (n == 0) begin
               t1 = k;
               r1 = int'($signed(out_data4));
               n  = 1;
            end else begin
               t2 = k;
               r2 = int'($signed(out_data4));
               break;
            end
         end
      end
      in_valid4 = 1'b0;
      total++;
      if (r1 !== 45) $display("FAIL b2b_first: got %0d want 45", r1); else pass_cnt++;
      total++;
      if (r2 !== 44) $display("FAIL b2b_second: got %0d want 44", r2); else pass_cnt++;
      total++;
      if (t2 - t1 !== 4) $display("FAIL b2b_spacing: got %0d want 4", t2 - t1); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      bit got;
      set_uniform(1, 1, 0, 0, 1'b0);
      out_ready = 1'b0;
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      set_uniform(2, 1, 0, 0, 1'b0);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid4) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (got !== 1'b1) $display("FAIL stall_result_timeout: out_valid=%0b want 1", got); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (out_valid4 !== 1'b1 || out_data4 !== 8'd9 || in_ready4 !== 1'b0)
            $display("FAIL stall_hold c%0d: valid=%0b data=%0d ready=%0b, want 1 9 0",
                     c, out_valid4, out_data4, in_ready4);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      total++;
      if (out_valid4 !== 1'b0) $display("FAIL stall_release: out_valid=%0b want 0", out_valid4); else pass_cnt++;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid4) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (got !== 1'b1 || out_data4 !== 8'd18)
         $display("FAIL stall_next: valid=%0b data=%0d, want 1 18", got, out_data4);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid1 = 1'b0;
      in_valid4 = 1'b0;
      out_ready = 1'b1;
      set_uniform(0, 0, 0, 0, 1'b0);
      test_reset();
      test_ones();
      test_saturate();
      test_lanes();
      test_shift_floor();
      test_mid_reset();
      test_back_to_back();
      test_stall();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
